ahb2_rr_arbiter: RTL and testbench
==================================

Name: ahb2_rr_arbiter

Overview:
- Parametrised AHB2 bus arbiter for NUM_MST masters; successor to the fixed single-master AHB2 master/slave interface definitions.
- Takes per-master hbusreq/hlock and the muxed address-phase control (htrans, hburst, hready, hresp).
- Drives one-hot hgrant, the address-phase owner index hmaster, and hmastlock.
- Round-robin fairness; never breaks a fixed-length burst; parks on a default master when idle.

Parameters:
- NUM_MST, 4, number of masters (2..16).
- DEFAULT_MST, 0, park master when no request is pending (0..NUM_MST-1).
- IDX_W, $clog2(NUM_MST), width of hmaster.

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NUM_MST  per-master bus request.
- hlock  in  NUM_MST  per-master lock request; ignored unless AHB2_ARB_LOCK_EN.
- htrans  in  2  muxed htrans of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed hburst.
- hready  in  1  bus hready.
- hresp  in  2  bus hresp (OKAY=0, ERROR=1).
- hgrant  out  NUM_MST  one-hot grant.
- hmaster  out  IDX_W  index of the master owning the address phase.
- hmastlock  out  1  current transfer is locked.

Behaviour:
- The interface is decided as one clock, hclk, and reset hreset, which is synchronous and active-high.
- Reset values: gnt_idx=DEFAULT_MST; hgrant=one-hot(DEFAULT_MST); hmaster=DEFAULT_MST; hmastlock=0; beat counter cnt=0.
- hgrant is the combinational one-hot decode of the registered gnt_idx.

Beat counter (cnt, 5 bits):
- Updated only at edges with hready=1.
- NONSEQ with a fixed burst loads len-1: INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
- NONSEQ with SINGLE or INCR loads 0.
- SEQ decrements cnt, saturating at 0.
- IDLE clears cnt to 0. BUSY holds cnt.
- hresp=ERROR with hready=0 clears cnt to 0 (burst aborted).

Arbitration:
- arb_ok is true when hready=1 and the next value of cnt is 0, i.e. the last beat address is accepted this edge or the bus is idle.
- On an edge with arb_ok:
  - Scan round-robin from (gnt_idx+1) mod NUM_MST and pick the first hbusreq set.
  - If the current owner is the only requester, it keeps the grant.
  - If there are no requests, gnt_idx <= DEFAULT_MST.
- Without arb_ok, gnt_idx holds.

Ownership:
- On every edge with hready=1, hmaster <= gnt_idx.
- Handover latency: grant changes at edge E and hmaster changes at the next hready=1 edge. The old master drives IDLE in between (one-cycle bubble, by design).
- hready=0 freezes gnt_idx, hmaster, cnt and hmastlock regardless of request changes.
- hreset asserted mid-burst returns all state to reset values on the next edge.
- INCR (undefined length) bursts may be re-arbitrated after any accepted beat.

Optional Feature:
- Macro AHB2_ARB_LOCK_EN.
- Defined:
  - If hlock[gnt_idx]=1 on an arb_ok edge, gnt_idx holds regardless of other requests.
  - On every hready=1 edge, hmastlock <= hlock[gnt_idx].
- Undefined:
  - hlock is unused.
  - hmastlock is constant 0.
  - Arbitration is pure round-robin.

Test Plan:
- Reset, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0; hgrant stays 4'b0001 for 10 cycles.
- hbusreq=4'b1010 held, owner issues SINGLE transfers, hready=1 -> grant alternates 1,3,1,3; hmaster follows one cycle after each grant change.
- Master 2 granted and issues INCR8 (NONSEQ + 7 SEQ) while master 1 requests -> hgrant stays 4'b0100 until the 8th beat address is accepted, then becomes 4'b0010.
- hready=0 for 5 cycles during an INCR4 with requests changing -> hgrant, hmaster and cnt unchanged; the burst resumes and handover occurs after beat 4.
- ERROR response (hresp=1, hready=0) on beat 2 of a WRAP8 -> cnt cleared; next hready=1 edge re-arbitrates to the waiting master.
- With AHB2_ARB_LOCK_EN, master 3 requests with hlock=1 while masters 0-2 also request -> master 3 keeps the grant across three bursts and hmastlock=1; after hlock drops, grant goes to master 0.

Source files
------------

// File: rtl/ahb2_rr_arbiter.sv
// ahb2_rr_arbiter: round-robin AHB2 bus arbiter for NUM_MST masters.
// Fixed-length bursts are never broken, and the bus parks on DEFAULT_MST
// when no master is requesting.
// Optional feature: define AHB2_ARB_LOCK_EN to honour hlock. This keeps the
// grant with a locking owner and drives hmastlock. When the macro is
// undefined, hlock is ignored and hmastlock is tied low.
module ahb2_rr_arbiter #(
    parameter int NUM_MST     = 4,
    parameter int DEFAULT_MST = 0,
    parameter int IDX_W       = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
    output logic [NUM_MST-1:0] hgrant,
    output logic [IDX_W-1:0]   hmaster,
    output logic               hmastlock
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } transE;

    localparam logic [1:0] RESP_ERROR = 2'd1;

    logic [IDX_W-1:0] gntIdx_q;
    logic [IDX_W-1:0] gntIdx_d;
    logic [IDX_W-1:0] hmaster_q;
    logic [4:0]       cnt_q;
    logic [4:0]       cnt_d;
    logic [4:0]       burstLen;
    logic             arbOk;
    logic             rrFound;
    logic [IDX_W-1:0] rrIdx;
    logic [IDX_W-1:0] candIdx;
    int               cand;
    logic             lockHold;

    // Beats remaining after a NONSEQ, taken from the burst type
    always_comb begin
        burstLen = 5'd0;
        case (hburst)
            3'd2, 3'd3: burstLen = 5'd3;
            3'd4, 3'd5: burstLen = 5'd7;
            3'd6, 3'd7: burstLen = 5'd15;
            default:    burstLen = 5'd0;
        endcase
    end

    // Next beat count; an ERROR during a wait state aborts the burst
    always_comb begin
        cnt_d = cnt_q;
        if (hready) begin
            case (transE'(htrans))
                TRANS_NONSEQ: cnt_d = burstLen;
                TRANS_SEQ:    cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                TRANS_IDLE:   cnt_d = 5'd0;
                default:      cnt_d = cnt_q;
            endcase
        end else if (hresp == RESP_ERROR) begin
            cnt_d = 5'd0;
        end
    end

    assign arbOk = hready && (cnt_d == 5'd0);

    // Round-robin scan starting after the current owner, ending on the owner itself
    always_comb begin
        rrFound = 1'b0;
        rrIdx   = gntIdx_q;
        candIdx = gntIdx_q;
        cand    = 0;
        for (int i = 1; i <= NUM_MST; i++) begin
            cand = int'(gntIdx_q) + i;
            if (cand >= NUM_MST) begin
                cand = cand - NUM_MST;
            end
            candIdx = IDX_W'(cand);
            if (!rrFound && hbusreq[candIdx]) begin
                rrFound = 1'b1;
                rrIdx   = candIdx;
            end
        end
    end

`ifdef AHB2_ARB_LOCK_EN
    logic hmastLock_q;

    assign lockHold = hlock[gntIdx_q];

    // Locked flag follows the owner's hlock whenever the address phase advances
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hmastLock_q <= 1'b0;
        end else if (hready) begin
            hmastLock_q <= hlock[gntIdx_q];
        end
    end

    assign hmastlock = hmastLock_q;
`else
    logic unused_hlock;

    assign lockHold     = 1'b0;
    assign unused_hlock = ^hlock;
    assign hmastlock    = 1'b0;
`endif

    // Grant decision: only re-arbitrate at a burst boundary or when the bus is idle
    always_comb begin
        gntIdx_d = gntIdx_q;
        if (arbOk && !lockHold) begin
            if (rrFound) begin
                gntIdx_d = rrIdx;
            end else begin
                gntIdx_d = IDX_W'(DEFAULT_MST);
            end
        end
    end

    // Grant, address-phase owner and beat counter registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            gntIdx_q  <= IDX_W'(DEFAULT_MST);
            hmaster_q <= IDX_W'(DEFAULT_MST);
            cnt_q     <= 5'd0;
        end else begin
            gntIdx_q <= gntIdx_d;
            cnt_q    <= cnt_d;
            if (hready) begin
                hmaster_q <= gntIdx_q;
            end
        end
    end

    // One-hot grant decoded from the registered owner index
    always_comb begin
        hgrant           = '0;
        hgrant[gntIdx_q] = 1'b1;
    end

    assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb2_rr_arbiter.sv
// tb_ahb2_rr_arbiter: directed self-checking bench for ahb2_rr_arbiter.
// The lock scenario is built only when AHB2_ARB_LOCK_EN is defined.
module tb_ahb2_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int compareCount;
    int mismatchCount;

    ahb2_rr_arbiter #(
        .NUM_MST(4),
        .DEFAULT_MST(0)
    ) dut (
        .hclk(hclk),
        .hreset(hreset),
        .hbusreq(hbusreq),
        .hlock(hlock),
        .htrans(htrans),
        .hburst(hburst),
        .hready(hready),
        .hresp(hresp),
        .hgrant(hgrant),
        .hmaster(hmaster),
        .hmastlock(hmastlock)
    );

    // Free-running bus clock
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Counts one comparison and reports it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of bus inputs and lets one clock edge pass
    task automatic applyStimulus(input logic [3:0] req, input logic [1:0] trans,
                                 input logic [2:0] burst, input logic rdy,
                                 input logic [1:0] resp);
        hbusreq = req;
        htrans  = trans;
        hburst  = burst;
        hready  = rdy;
        hresp   = resp;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [3:0] rrGrant [4];
        logic [1:0] rrMaster [4];
        logic [3:0] waitReq [5];

        compareCount  = 0;
        mismatchCount = 0;
        hreset  = 1'b1;
        hlock   = 4'b0000;
        rrGrant  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        rrMaster = '{2'd0, 2'd1, 2'd3, 2'd1};
        waitReq  = '{4'b1111, 4'b0001, 4'b1000, 4'b0100, 4'b0001};

        // Reset and parking on the default master
        applyStimulus(4'b0000, IDLE, SINGLE, 1'b1, 2'd0);
        applyStimulus(4'b0000, IDLE, SINGLE, 1'b1, 2'd0);
        hreset = 1'b0;
        checkOutput("reset_hgrant", 32'(hgrant), 32'h1);
        checkOutput("reset_hmaster", 32'(hmaster), 32'h0);
        checkOutput("reset_hmastlock", 32'(hmastlock), 32'h0);
        checkOutput("reset_cnt", 32'(dut.cnt_q), 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, IDLE, SINGLE, 1'b1, 2'd0);
            checkOutput($sformatf("park_hgrant_%0d", i), 32'(hgrant), 32'h1);
        end
        checkOutput("park_hmaster", 32'(hmaster), 32'h0);

        // Masters 1 and 3 alternate on SINGLE transfers
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1010, NONSEQ, SINGLE, 1'b1, 2'd0);
            checkOutput($sformatf("rr_hgrant_%0d", i), 32'(hgrant), 32'(rrGrant[i]));
            checkOutput($sformatf("rr_hmaster_%0d", i), 32'(hmaster), 32'(rrMaster[i]));
        end

        // Master 2 takes the bus and runs an INCR8 while master 1 waits
        applyStimulus(4'b0100, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("incr8_grant_m2", 32'(hgrant), 32'h4);
        checkOutput("incr8_hmaster_old", 32'(hmaster), 32'h3);
        applyStimulus(4'b0100, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("incr8_hmaster_m2", 32'(hmaster), 32'h2);
        applyStimulus(4'b0110, NONSEQ, INCR8, 1'b1, 2'd0);
        checkOutput("incr8_beat1_hgrant", 32'(hgrant), 32'h4);
        checkOutput("incr8_beat1_cnt", 32'(dut.cnt_q), 32'd7);
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(4'b0110, SEQ, INCR8, 1'b1, 2'd0);
            checkOutput($sformatf("incr8_beat%0d_hgrant", i), 32'(hgrant), 32'h4);
        end
        applyStimulus(4'b0110, SEQ, INCR8, 1'b1, 2'd0);
        checkOutput("incr8_beat8_hgrant", 32'(hgrant), 32'h2);
        checkOutput("incr8_beat8_hmaster", 32'(hmaster), 32'h2);
        applyStimulus(4'b0010, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("handover_hmaster_m1", 32'(hmaster), 32'h1);
        checkOutput("handover_hgrant_m1", 32'(hgrant), 32'h2);

        // INCR4 from master 1 stalled by five wait states
        applyStimulus(4'b0011, NONSEQ, INCR4, 1'b1, 2'd0);
        checkOutput("incr4_beat1_cnt", 32'(dut.cnt_q), 32'd3);
        applyStimulus(4'b0011, SEQ, INCR4, 1'b1, 2'd0);
        checkOutput("incr4_beat2_cnt", 32'(dut.cnt_q), 32'd2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(waitReq[i], SEQ, INCR4, 1'b0, 2'd0);
            checkOutput($sformatf("wait%0d_hgrant", i), 32'(hgrant), 32'h2);
            checkOutput($sformatf("wait%0d_hmaster", i), 32'(hmaster), 32'h1);
            checkOutput($sformatf("wait%0d_cnt", i), 32'(dut.cnt_q), 32'd2);
        end
        applyStimulus(4'b0001, SEQ, INCR4, 1'b1, 2'd0);
        checkOutput("incr4_beat3_hgrant", 32'(hgrant), 32'h2);
        applyStimulus(4'b0001, SEQ, INCR4, 1'b1, 2'd0);
        checkOutput("incr4_beat4_hgrant", 32'(hgrant), 32'h1);
        checkOutput("incr4_beat4_hmaster", 32'(hmaster), 32'h1);

        // WRAP8 from master 0 aborted by ERROR on beat 2
        applyStimulus(4'b0001, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("wrap8_hmaster_m0", 32'(hmaster), 32'h0);
        applyStimulus(4'b0101, NONSEQ, WRAP8, 1'b1, 2'd0);
        checkOutput("wrap8_beat1_cnt", 32'(dut.cnt_q), 32'd7);
        applyStimulus(4'b0101, SEQ, WRAP8, 1'b1, 2'd0);
        checkOutput("wrap8_beat2_cnt", 32'(dut.cnt_q), 32'd6);
        applyStimulus(4'b0101, SEQ, WRAP8, 1'b0, 2'd1);
        checkOutput("error_cnt", 32'(dut.cnt_q), 32'd0);
        checkOutput("error_hgrant", 32'(hgrant), 32'h1);
        applyStimulus(4'b0101, IDLE, WRAP8, 1'b1, 2'd1);
        checkOutput("error_rearb_hgrant", 32'(hgrant), 32'h4);
        checkOutput("error_rearb_hmaster", 32'(hmaster), 32'h0);

        // Reset asserted in the middle of an INCR16
        applyStimulus(4'b0110, NONSEQ, INCR16, 1'b1, 2'd0);
        checkOutput("incr16_cnt", 32'(dut.cnt_q), 32'd15);
        checkOutput("incr16_hmaster", 32'(hmaster), 32'h2);
        hreset = 1'b1;
        applyStimulus(4'b0110, SEQ, INCR16, 1'b1, 2'd0);
        hreset = 1'b0;
        checkOutput("midreset_hgrant", 32'(hgrant), 32'h1);
        checkOutput("midreset_hmaster", 32'(hmaster), 32'h0);
        checkOutput("midreset_cnt", 32'(dut.cnt_q), 32'd0);
        checkOutput("midreset_hmastlock", 32'(hmastlock), 32'h0);

`ifdef AHB2_ARB_LOCK_EN
        // Master 3 locks the bus over three INCR4 bursts
        hlock = 4'b1000;
        applyStimulus(4'b1000, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("lock_grant_m3", 32'(hgrant), 32'h8);
        applyStimulus(4'b1111, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("lock_hold_hgrant", 32'(hgrant), 32'h8);
        checkOutput("lock_hmastlock", 32'(hmastlock), 32'h1);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(4'b1111, NONSEQ, WRAP4, 1'b1, 2'd0);
            checkOutput($sformatf("lock_b%0d_nonseq_hgrant", b), 32'(hgrant), 32'h8);
            for (int s = 0; s < 3; s++) begin
                applyStimulus(4'b1111, SEQ, WRAP4, 1'b1, 2'd0);
                checkOutput($sformatf("lock_b%0d_seq%0d_hgrant", b, s), 32'(hgrant), 32'h8);
                checkOutput($sformatf("lock_b%0d_seq%0d_hmastlock", b, s), 32'(hmastlock), 32'h1);
            end
        end
        hlock = 4'b0000;
        applyStimulus(4'b1111, IDLE, SINGLE, 1'b1, 2'd0);
        checkOutput("unlock_hgrant", 32'(hgrant), 32'h1);
        checkOutput("unlock_hmastlock", 32'(hmastlock), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
